// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the HI/LO multiply/divide engine
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITER_LAST = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef enum logic {
        CLS_MUL = 1'b0,
        CLS_DIV = 1'b1
    } op_class_e;

    // Magnitude of a two's-complement value; 0x80000000 maps to itself as unsigned
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add (multiply) or restoring-subtract (divide) step
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [31:0] acc_i,
    input  logic [31:0] opr_i,
    input  logic [31:0] oper_i,
    input  op_class_e   cls_i,
    output logic [31:0] acc_o,
    output logic [31:0] opr_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + (opr_i[0] ? {1'b0, oper_i} : 33'd0);
        shifted = {acc_i, opr_i[31]};
        // 34 bits so an unsigned partial remainder above 2^32 still yields a correct borrow
        diff    = {1'b0, shifted} - {2'b00, oper_i};
        if (cls_i == CLS_DIV) begin
            if (!diff[33]) begin
                acc_o = diff[31:0];
                opr_o = {opr_i[30:0], 1'b1};
            end else begin
                acc_o = shifted[31:0];
                opr_o = {opr_i[30:0], 1'b0};
            end
        end else begin
            acc_o = sum[32:1];
            opr_o = {sum[0], opr_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU engine owning HI/LO
// Optional MULDIV_FAST_MULT_EN: single-cycle '*' product for MULT/MULTU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_class_e     cls_q, cls_d;
    logic          neg_res_q, neg_res_d;
    logic          neg_rem_q, neg_rem_d;
    logic          b_zero_q, b_zero_d;
    logic [31:0]   raw_a_q, raw_a_d;
    // acc: product high half / partial remainder; opr: multiplier / quotient; oper: multiplicand / divisor
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   opr_q, opr_d;
    logic [31:0]   oper_q, oper_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    logic          is_signed;
    op_class_e     cls_in;
    logic [31:0]   abs_a, abs_b;
    logic [31:0]   acc_step, opr_step;
    logic [63:0]   prod_fix;
    logic [31:0]   quo_fix, rem_fix;

    muldiv_step u_step (
        .acc_i  (acc_q),
        .opr_i  (opr_q),
        .oper_i (oper_q),
        .cls_i  (cls_q),
        .acc_o  (acc_step),
        .opr_o  (opr_step)
    );

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        cls_in    = ((op == OP_DIV) || (op == OP_DIVU)) ? CLS_DIV : CLS_MUL;
        abs_a     = abs32(opa, is_signed);
        abs_b     = abs32(opb, is_signed);
        prod_fix  = neg_res_q ? (~{acc_q, opr_q} + 64'd1) : {acc_q, opr_q};
        quo_fix   = neg_res_q ? (~opr_q + 32'd1) : opr_q;
        rem_fix   = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cls_d     = cls_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        raw_a_d   = raw_a_q;
        acc_d     = acc_q;
        opr_d     = opr_q;
        oper_d    = oper_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    cls_d     = cls_in;
                    neg_res_d = is_signed && (opa[31] ^ opb[31]);
                    neg_rem_d = is_signed && opa[31];
                    b_zero_d  = (opb == 32'd0);
                    raw_a_d   = opa;
                    acc_d     = 32'd0;
                    opr_d     = (cls_in == CLS_DIV) ? abs_a : abs_b;
                    oper_d    = (cls_in == CLS_DIV) ? abs_b : abs_a;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CALC;
`ifdef MULDIV_FAST_MULT_EN
                    if (cls_in == CLS_MUL) begin
                        {acc_d, opr_d} = 64'(abs_a) * 64'(abs_b);
                        state_d        = ST_FINISH;
                    end
`endif
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                opr_d = opr_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER_LAST)) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (cls_q == CLS_MUL) begin
                    {hi_d, lo_d} = prod_fix;
                    dbz_d        = 1'b0;
                end else if (b_zero_q) begin
                    hi_d  = raw_a_q;
                    lo_d  = 32'hFFFF_FFFF;
                    dbz_d = 1'b1;
                end else begin
                    hi_d  = rem_fix;
                    lo_d  = quo_fix;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cls_q     <= CLS_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            raw_a_q   <= 32'd0;
            acc_q     <= 32'd0;
            opr_q     <= 32'd0;
            oper_q    <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cls_q     <= cls_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            raw_a_q   <= raw_a_d;
            acc_q     <= acc_d;
            opr_q     <= opr_d;
            oper_q    <= oper_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          bsy;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    chk("busy_cycles", 64'(busy_run), 64'(e.bsy));
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed);
        exp_t e;
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.dbz = ed;
            e.lat = 34;
            e.bsy = 33;
            e.t0  = cyc;
`ifdef MULDIV_FAST_MULT_EN
            if (!o[1]) begin
                e.lat = 2;
                e.bsy = 1;
            end
`endif
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'b11;
        opa   = 32'hDEAD_BEEF;
        opb   = 32'h0BAD_F00D;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        issue(2'b11, 32'd100, 32'd7, 1'b1, 32'h0000_0002, 32'h0000_000E, 1'b0);
        wait_done();
        // start in the done cycle is accepted
        issue(2'b11, 32'd5, 32'd0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        @(negedge clk);
        chk("dbz_hold", 64'(div_by_zero), 64'd1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done();
        @(negedge clk);

        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo_kept", 64'(lo), 64'h8000_0000);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthilo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

        issue(2'b01, 32'd3, 32'd4, 1'b1, 32'h0000_0000, 32'h0000_000C, 1'b0);
`ifndef MULDIV_FAST_MULT_EN
        repeat (3) @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hAAAA_5555;
        start = 1'b1;
        op    = 2'b11;
        opa   = 32'd1;
        opb   = 32'd1;
        @(negedge clk);
        hi_we = 1'b0;
        start = 1'b0;
        chk("hi_we_busy", 64'(hi), 64'hCAFE_F00D);
`endif
        wait_done();
        repeat (40) @(negedge clk);

        issue(2'b10, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);

        issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        wait_done();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
